// File: rtl/deparser_pkg.sv
// Shared types and constants for the deparser configuration path.
package deparser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_RD_WAIT
  } state_e;

  // Head tag bit positions on the deparser input
  localparam int TAG_VALID = 0;
  localparam int TAG_START = 1;
  localparam int TAG_TAIL  = 2;

  localparam int          RULE_LAYER_LSB   = 24;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant; search starts at i_ptr and wraps.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt
);

  logic found;
  int   idx;

  always_comb begin
    o_gnt = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(i_ptr) + k) % N_REQ;
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/deparser_rule_arbiter.sv
// Arbitrates config masters onto the deparser rule bus; writes wait for the
// packet pipeline to drain, reads are tracked with a timeout.
module deparser_rule_arbiter
  import deparser_pkg::*;
#(
  parameter int          N_REQ        = 2,
  parameter int          DRAIN_CYCLES = 4,
  parameter int          RD_TIMEOUT   = 64,
  parameter logic [31:0] ERR_DATA     = ERR_DATA_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic [N_REQ-1:0]       i_req_wr,
  input  logic [N_REQ-1:0][31:0] i_req_addr,
  input  logic [N_REQ-1:0][31:0] i_req_wdata,
  output logic [N_REQ-1:0]       o_rsp_valid,
  output logic                   o_rsp_err,
  output logic [31:0]            o_rsp_rdata,
  output logic                   o_rule_wren,
  output logic                   o_rule_rden,
  output logic [31:0]            o_rule_addr,
  output logic [31:0]            o_rule_wdata,
  input  logic                   i_rule_rdata_valid,
  input  logic [31:0]            i_rule_rdata,
  input  logic                   i_pkt_start,
  input  logic                   i_pkt_end,
  output logic                   o_pkt_hold
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int CW = $clog2(RD_TIMEOUT);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, id_q, id_d, gnt_id;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              in_pkt_q, in_pkt_d, hold_q, hold_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d, gnt;
  logic              rsp_err_q, rsp_err_d, acc;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
    .i_req (i_req_valid),
    .i_ptr (ptr_q),
    .o_gnt (gnt)
  );

  always_comb begin
    gnt_id = '0;
    for (int k = 0; k < N_REQ; k++)
      if (gnt[k]) gnt_id = PW'(k);
  end

  // Ready is withheld during reset so every output reads 0 while it is high
  assign o_req_ready  = (state_q == ST_IDLE && !i_rst) ? gnt : '0;
  assign acc          = |(i_req_valid & o_req_ready);
  assign o_rule_wren  = (state_q == ST_WR_ISSUE);
  assign o_rule_rden  = (state_q == ST_RD_ISSUE);
  assign o_rule_addr  = (state_q != ST_IDLE) ? addr_q  : '0;
  assign o_rule_wdata = (state_q != ST_IDLE) ? wdata_q : '0;
  assign o_pkt_hold   = hold_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_rsp_rdata  = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_cnt_d    = rd_cnt_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        rd_cnt_d = '0;
        if (acc) begin
          id_d    = gnt_id;
          addr_d  = i_req_addr[gnt_id];
          wdata_d = i_req_wdata[gnt_id];
          ptr_d   = (gnt_id == PW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
          state_d = i_req_wr[gnt_id] ? ST_QUIESCE : ST_RD_ISSUE;
        end
      end
      ST_QUIESCE:
        if (!in_pkt_q && drain_q == '0) state_d = ST_WR_ISSUE;
      ST_WR_ISSUE: begin
        rsp_valid_d[id_q] = 1'b1;
        state_d           = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        // counting from the issue cycle puts the timeout response RD_TIMEOUT after rden
        rd_cnt_d = rd_cnt_q + 1'b1;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (i_rule_rdata_valid) begin
          rsp_valid_d[id_q] = 1'b1;
          rsp_rdata_d       = i_rule_rdata;
          state_d           = ST_IDLE;
        end else if (rd_cnt_q == CW'(RD_TIMEOUT - 1)) begin
          rsp_valid_d[id_q] = 1'b1;
          rsp_err_d         = 1'b1;
          rsp_rdata_d       = ERR_DATA;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    hold_d = (state_d == ST_QUIESCE) || (state_d == ST_WR_ISSUE);
  end

  // A start+end beat is a complete packet, so it leaves nothing in flight
  always_comb begin
    in_pkt_d = in_pkt_q;
    if (i_pkt_start && !i_pkt_end) in_pkt_d = 1'b1;
    else if (i_pkt_end)            in_pkt_d = 1'b0;
    drain_d = drain_q;
    if (i_pkt_start || i_pkt_end) drain_d = DW'(DRAIN_CYCLES);
    else if (drain_q != '0)       drain_d = drain_q - 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_cnt_q    <= '0;
      drain_q     <= '0;
      in_pkt_q    <= 1'b0;
      hold_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_cnt_q    <= rd_cnt_d;
      drain_q     <= drain_d;
      in_pkt_q    <= in_pkt_d;
      hold_q      <= hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_deparser_rule_arbiter.sv
// Directed bench for deparser_rule_arbiter with hand-computed expectations.
module tb_deparser_rule_arbiter;

  localparam int DRAIN = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [1:0]       i_req_valid, i_req_wr, o_req_ready, o_rsp_valid;
  logic [1:0][31:0] i_req_addr, i_req_wdata;
  logic             o_rsp_err, o_rule_wren, o_rule_rden, o_pkt_hold;
  logic [31:0]      o_rsp_rdata, o_rule_addr, o_rule_wdata, i_rule_rdata;
  logic             i_rule_rdata_valid, i_pkt_start, i_pkt_end;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  deparser_rule_arbiter dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_req_valid        (i_req_valid),
    .o_req_ready        (o_req_ready),
    .i_req_wr           (i_req_wr),
    .i_req_addr         (i_req_addr),
    .i_req_wdata        (i_req_wdata),
    .o_rsp_valid        (o_rsp_valid),
    .o_rsp_err          (o_rsp_err),
    .o_rsp_rdata        (o_rsp_rdata),
    .o_rule_wren        (o_rule_wren),
    .o_rule_rden        (o_rule_rden),
    .o_rule_addr        (o_rule_addr),
    .o_rule_wdata       (o_rule_wdata),
    .i_rule_rdata_valid (i_rule_rdata_valid),
    .i_rule_rdata       (i_rule_rdata),
    .i_pkt_start        (i_pkt_start),
    .i_pkt_end          (i_pkt_end),
    .o_pkt_hold         (o_pkt_hold)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  logic [1:0] g;
  int         seen;

  initial begin
    i_rst = 1'b1;
    i_req_valid = 2'b11; i_req_wr = '0; i_req_addr = '0; i_req_wdata = '0;
    i_rule_rdata_valid = 1'b0; i_rule_rdata = '0; i_pkt_start = 1'b0; i_pkt_end = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ready", o_req_ready, 0);
    chk("rst_outs", {o_rsp_valid, o_rsp_err, o_rule_wren, o_rule_rden, o_pkt_hold}, 0);
    chk("rst_addr", o_rule_addr, 0);
    i_req_valid = '0;
    i_rst = 1'b0;
    cyc();

    // single write from req0
    i_req_valid = 2'b01; i_req_wr = 2'b01;
    i_req_addr[0] = 32'h0100_0002; i_req_wdata[0] = 32'h55;
    #1 chk("wr_ready", o_req_ready, 2'b01);
    cyc(); i_req_valid = '0;
    chk("wr_t1_hold", o_pkt_hold, 1); chk("wr_t1_wren", o_rule_wren, 0);
    cyc();
    chk("wr_t2_wren", o_rule_wren, 1); chk("wr_t2_addr", o_rule_addr, 32'h0100_0002);
    chk("wr_t2_wdata", o_rule_wdata, 32'h55); chk("wr_t2_hold", o_pkt_hold, 1);
    cyc();
    chk("wr_t3_rsp", o_rsp_valid, 2'b01); chk("wr_t3_err", o_rsp_err, 0);
    chk("wr_t3_rdata", o_rsp_rdata, 0); chk("wr_t3_hold", o_pkt_hold, 0);
    chk("wr_t3_wren", o_rule_wren, 0);

    // contention from reset: alternate grants, responses routed back
    i_rst = 1'b1; #2 i_rst = 1'b0;
    cyc();
    i_req_wr = '0; i_req_addr[0] = 32'h0000_0010; i_req_addr[1] = 32'h0200_0020;
    i_req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      g = (n % 2 == 0) ? 2'b01 : 2'b10;
      #1 chk("ct_ready", o_req_ready, g);
      cyc();
      chk("ct_rden", o_rule_rden, 1);
      chk("ct_addr", o_rule_addr, (g == 2'b01) ? 32'h0000_0010 : 32'h0200_0020);
      cyc();
      i_rule_rdata_valid = 1'b1; i_rule_rdata = 32'hA000_0000 + n;
      cyc();
      i_rule_rdata_valid = 1'b0;
      chk("ct_rsp", o_rsp_valid, g);
      chk("ct_rdata", o_rsp_rdata, 32'hA000_0000 + n);
      chk("ct_err", o_rsp_err, 0);
    end
    i_req_valid = '0;

    // quiesce: write while a packet is in flight
    i_pkt_start = 1'b1; cyc(); i_pkt_start = 1'b0;
    i_req_valid = 2'b10; i_req_wr = 2'b10;
    i_req_addr[1] = 32'h0100_0040; i_req_wdata[1] = 32'h77;
    #1 chk("qs_ready", o_req_ready, 2'b10);
    for (int i = 1; i <= 10; i++) begin
      cyc(); i_req_valid = '0;
      if (i == 10) i_pkt_end = 1'b1;
      chk("qs_hold", o_pkt_hold, 1); chk("qs_wren_pkt", o_rule_wren, 0);
    end
    cyc(); i_pkt_end = 1'b0;
    chk("qs_wren_e0", o_rule_wren, 0);
    for (int n = 1; n <= DRAIN; n++) begin
      cyc();
      chk("qs_wren_drain", o_rule_wren, 0); chk("qs_hold_drain", o_pkt_hold, 1);
    end
    cyc();
    chk("qs_wren", o_rule_wren, 1); chk("qs_addr", o_rule_addr, 32'h0100_0040);
    chk("qs_wdata", o_rule_wdata, 32'h77);
    cyc();
    chk("qs_rsp", o_rsp_valid, 2'b10);

    // read timeout: no data returned
    i_req_valid = 2'b01; i_req_wr = '0; i_req_addr[0] = 32'h0300_0004;
    #1 chk("to_ready", o_req_ready, 2'b01);
    cyc(); i_req_valid = '0;
    chk("to_rden", o_rule_rden, 1);
    seen = 0;
    for (int i = 1; i <= 63; i++) begin
      cyc();
      if (o_rsp_valid != 0) seen++;
    end
    chk("to_early", seen, 0);
    cyc();
    chk("to_rsp", o_rsp_valid, 2'b01); chk("to_err", o_rsp_err, 1);
    chk("to_rdata", o_rsp_rdata, 32'hDEAD_BEEF);

    // read with data on the final wait cycle
    i_req_valid = 2'b01;
    #1 chk("tl_ready", o_req_ready, 2'b01);
    cyc(); i_req_valid = '0;
    chk("tl_rden", o_rule_rden, 1);
    seen = 0;
    for (int i = 1; i <= 63; i++) begin
      cyc();
      if (o_rsp_valid != 0) seen++;
      if (i == 63) begin i_rule_rdata_valid = 1'b1; i_rule_rdata = 32'h1234_5678; end
    end
    chk("tl_early", seen, 0);
    cyc(); i_rule_rdata_valid = 1'b0;
    chk("tl_rsp", o_rsp_valid, 2'b01); chk("tl_err", o_rsp_err, 0);
    chk("tl_rdata", o_rsp_rdata, 32'h1234_5678);

    // reset during RD_WAIT
    i_req_valid = 2'b01; i_req_addr[0] = 32'h0100_0088;
    #1;
    cyc(); i_req_valid = '0;
    cyc(); cyc();
    chk("rm_addr_pre", o_rule_addr, 32'h0100_0088);
    #2 i_rst = 1'b1;
    #1;
    chk("rm_addr", o_rule_addr, 0);
    chk("rm_outs", {o_rsp_valid, o_rsp_err, o_rule_wren, o_rule_rden, o_pkt_hold}, 0);
    i_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (o_rsp_valid != 0) seen++;
    end
    chk("rm_norsp", seen, 0);
    i_req_valid = 2'b11; i_req_wr = '0;
    #1 chk("rm_ptr0", o_req_ready, 2'b01);
    cyc(); i_req_valid = '0;
    chk("rm_rden", o_rule_rden, 1);
    cyc(); i_rule_rdata_valid = 1'b1; i_rule_rdata = 32'h0000_00C3;
    cyc(); i_rule_rdata_valid = 1'b0;
    chk("rm_rsp", o_rsp_valid, 2'b01); chk("rm_rdata", o_rsp_rdata, 32'h0000_00C3);

    // single-beat packet then stray read data in IDLE
    i_pkt_start = 1'b1; i_pkt_end = 1'b1;
    cyc(); i_pkt_start = 1'b0; i_pkt_end = 1'b0;
    repeat (5) cyc();
    i_rule_rdata_valid = 1'b1; i_rule_rdata = 32'hBAD0_0001;
    cyc(); i_rule_rdata_valid = 1'b0;
    chk("sb_stray1", o_rsp_valid, 0);
    cyc();
    chk("sb_stray2", o_rsp_valid, 0);
    i_req_valid = 2'b01; i_req_wr = 2'b01;
    i_req_addr[0] = 32'h0200_0008; i_req_wdata[0] = 32'h99;
    #1 chk("sb_ready", o_req_ready, 2'b01);
    cyc(); i_req_valid = '0;
    cyc();
    chk("sb_wren", o_rule_wren, 1); chk("sb_wdata", o_rule_wdata, 32'h99);
    cyc();
    chk("sb_rsp", o_rsp_valid, 2'b01); chk("sb_rdata", o_rsp_rdata, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
